// File: rtl/cpu_data_mc.sv
// Multi-cycle accumulator data path: IDLE -> READ -> EXEC -> WB.
// ALU A operand is always ACC; B comes from IMM, the register file, data memory
// or PORT_IN. The result goes to ACC, the register file, data memory or PORT_OUT.
module cpu_data_mc #(
   parameter int unsigned WIDTH           = 8,
   parameter int unsigned REG_F_SEL_SIZE  = 4,
   parameter int unsigned D_MEM_ADDR_SIZE = 4
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       START,
   input  logic [2:0]                 ALU_OP,
   input  logic [1:0]                 IN_B_SEL,
   input  logic [1:0]                 DEST_SEL,
   input  logic [WIDTH-1:0]           IMM,
   input  logic [REG_F_SEL_SIZE-1:0]  REG_F_SEL,
   input  logic [D_MEM_ADDR_SIZE-1:0] D_MEM_ADDR,
   input  logic                       D_MEM_ADDR_MODE,
   input  logic [WIDTH-1:0]           PORT_IN,
   output logic [WIDTH-1:0]           ACC,
   output logic [WIDTH-1:0]           PORT_OUT,
   output logic                       FLAG_C,
   output logic                       FLAG_Z,
   output logic                       BUSY,
   output logic                       DONE
);

   localparam int unsigned REG_F_DEPTH = 1 << REG_F_SEL_SIZE;
   localparam int unsigned D_MEM_DEPTH = 1 << D_MEM_ADDR_SIZE;

   typedef enum logic [1:0] {StIdle, StRead, StExec, StWb} state_t;

   state_t                     state_q;
   logic [2:0]                 op_q;
   logic [1:0]                 bsel_q;
   logic [1:0]                 dest_q;
   logic [WIDTH-1:0]           imm_q;
   logic [REG_F_SEL_SIZE-1:0]  rsel_q;
   logic [D_MEM_ADDR_SIZE-1:0] addr_q;
   logic [WIDTH-1:0]           pin_q;
   logic [WIDTH-1:0]           b_q;
   logic [WIDTH-1:0]           res_q;

   logic [WIDTH-1:0] reg_f [REG_F_DEPTH];
   logic [WIDTH-1:0] d_mem [D_MEM_DEPTH];

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;

   // Extra top bit of the difference is the borrow, i.e. ACC < B unsigned.
   assign sum  = {1'b0, ACC} + {1'b0, b_q};
   assign diff = {1'b0, ACC} - {1'b0, b_q};

   // ALU: result and carry for the latched operation; PASS ops keep the old carry.
   always_comb begin
      alu_res = '0;
      alu_c   = FLAG_C;
      case (op_q)
         3'd0: begin alu_res = sum[WIDTH-1:0];  alu_c = sum[WIDTH];  end
         3'd1: begin alu_res = diff[WIDTH-1:0]; alu_c = diff[WIDTH]; end
         3'd2: begin alu_res = ACC & b_q;       alu_c = 1'b0;        end
         3'd3: begin alu_res = ACC | b_q;       alu_c = 1'b0;        end
         3'd4: begin alu_res = ACC ^ b_q;       alu_c = 1'b0;        end
         3'd5: alu_res = ACC;
         3'd6: alu_res = b_q;
         default: begin alu_res = ACC >> 1;     alu_c = ACC[0];      end
      endcase
   end

   // Sequencer, operand/result registers, storage and registered outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= StIdle;
         op_q     <= '0;
         bsel_q   <= '0;
         dest_q   <= '0;
         imm_q    <= '0;
         rsel_q   <= '0;
         addr_q   <= '0;
         pin_q    <= '0;
         b_q      <= '0;
         res_q    <= '0;
         ACC      <= '0;
         PORT_OUT <= '0;
         FLAG_C   <= 1'b0;
         FLAG_Z   <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         for (int i = 0; i < REG_F_DEPTH; i++) reg_f[i] <= '0;
         for (int i = 0; i < D_MEM_DEPTH; i++) d_mem[i] <= '0;
      end else begin
         DONE <= 1'b0;
         case (state_q)
            StIdle: begin
               if (START) begin
                  op_q   <= ALU_OP;
                  bsel_q <= IN_B_SEL;
                  dest_q <= DEST_SEL;
                  imm_q  <= IMM;
                  rsel_q <= REG_F_SEL;
                  pin_q  <= PORT_IN;
                  // Indirect address uses register contents before this op writes anything.
                  addr_q <= D_MEM_ADDR_MODE ? reg_f[REG_F_SEL][D_MEM_ADDR_SIZE-1:0]
                                            : D_MEM_ADDR;
                  BUSY    <= 1'b1;
                  state_q <= StRead;
               end
            end
            StRead: begin
               case (bsel_q)
                  2'd0:    b_q <= imm_q;
                  2'd1:    b_q <= reg_f[rsel_q];
                  2'd2:    b_q <= d_mem[addr_q];
                  default: b_q <= pin_q;
               endcase
               state_q <= StExec;
            end
            StExec: begin
               res_q  <= alu_res;
               FLAG_C <= alu_c;
               FLAG_Z <= (alu_res == '0);
               if (dest_q == 2'd0) ACC <= alu_res;
               state_q <= StWb;
            end
            default: begin
               case (dest_q)
                  2'd1:    reg_f[rsel_q] <= res_q;
                  2'd2:    d_mem[addr_q] <= res_q;
                  2'd3:    PORT_OUT      <= res_q;
                  default: ;
               endcase
               DONE    <= 1'b1;
               BUSY    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
